// File: rtl/dpipe_pkg.sv
// Shared helpers for the dpipe delay line: fill-counter width and per-stage operation decode.
package dpipe_pkg;

  // Width needed to count 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_CLEAR = 2'd2
  } stage_op_e;

  // Reset and flush both return a stage to its idle value; enable only matters otherwise.
  function automatic stage_op_e stage_op(input logic rst_n, input logic flush, input logic en);
    if (!rst_n || flush) return OP_CLEAR;
    if (en) return OP_LOAD;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/dpipe_stage.sv
// One {data, vld} register of the delay line with enable, flush and synchronous active-low reset.
module dpipe_stage
  import dpipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             vld;
  } word_t;

  word_t word_q;

  always_ff @(posedge clk) begin
    unique case (stage_op(rst_n, flush, en))
      OP_CLEAR: word_q <= '{data: RST_VAL, vld: 1'b0};
      OP_LOAD:  word_q <= '{data: d, vld: vld};
      default:  word_q <= word_q;
    endcase
  end

  assign q     = word_q.data;
  assign q_vld = word_q.vld;

endmodule

// File: rtl/dpipe_delay_line.sv
// WIDTH x STAGES delay line with valid tags, stall and flush; optional edge detect on the
// output word when DPIPE_EDGE_DET_EN is defined.
module dpipe_delay_line
  import dpipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        en_i,
  input  logic                        flush_i,
  input  logic [WIDTH-1:0]            d_i,
  input  logic                        vld_i,
  output logic [WIDTH-1:0]            d_o,
  output logic                        vld_o,
  output logic [cnt_w(STAGES)-1:0]    fill_o
`ifdef DPIPE_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0]            rise_o,
  output logic [WIDTH-1:0]            fall_o
`endif
);

  localparam int unsigned CW = cnt_w(STAGES);

  // Index 0 is the input word; index k is the output of stage k-1.
  logic [STAGES:0][WIDTH-1:0] data;
  logic [STAGES:0]            vld;

  assign data[0] = d_i;
  assign vld[0]  = vld_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dpipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .en    (en_i),
      .flush (flush_i),
      .d     (data[k]),
      .vld   (vld[k]),
      .q     (data[k+1]),
      .q_vld (vld[k+1])
    );
  end

  assign d_o   = data[STAGES];
  assign vld_o = vld[STAGES];

  // Occupancy tracked incrementally: one in, one out per advance, bounded to 0..STAGES.
  logic [CW-1:0] fill_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      fill_q <= '0;
    end else if (en_i) begin
      fill_q <= fill_q + CW'(vld_i) - CW'(vld[STAGES]);
    end
  end

  assign fill_o = fill_q;

`ifdef DPIPE_EDGE_DET_EN
  // Tracks d_o every cycle; reloaded with RST_VAL so no edge shows after reset/flush.
  logic [WIDTH-1:0] last_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      last_q <= RST_VAL;
    end else begin
      last_q <= d_o;
    end
  end

  assign rise_o = d_o & ~last_q;
  assign fall_o = ~d_o & last_q;
`endif

endmodule

// File: tb/tb_dpipe_delay_line.sv
// Directed bench for dpipe_delay_line: an 8x3 instance and a legacy 1x1 instance
// (edge-detect checks included when DPIPE_EDGE_DET_EN is defined).
module tb_dpipe_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-bit, 3-stage instance
  logic       a_rstn, a_en, a_flush, a_vld, a_vld_o;
  logic [7:0] a_d, a_d_o;
  logic [1:0] a_fill;
`ifdef DPIPE_EDGE_DET_EN
  logic [7:0] a_rise, a_fall;
`endif

  // legacy 1-bit, 1-stage instance
  logic       b_rstn, b_en, b_flush, b_vld, b_vld_o;
  logic [0:0] b_d, b_d_o;
  logic [0:0] b_fill;
`ifdef DPIPE_EDGE_DET_EN
  logic [0:0] b_rise, b_fall;
`endif

  dpipe_delay_line #(
    .WIDTH   (8),
    .STAGES  (3),
    .RST_VAL (8'hFF)
  ) dut_a (
    .clk_i   (clk),
    .rstn_i  (a_rstn),
    .en_i    (a_en),
    .flush_i (a_flush),
    .d_i     (a_d),
    .vld_i   (a_vld),
    .d_o     (a_d_o),
    .vld_o   (a_vld_o),
    .fill_o  (a_fill)
`ifdef DPIPE_EDGE_DET_EN
    ,
    .rise_o  (a_rise),
    .fall_o  (a_fall)
`endif
  );

  dpipe_delay_line #(
    .WIDTH   (1),
    .STAGES  (1),
    .RST_VAL (1'b1)
  ) dut_b (
    .clk_i   (clk),
    .rstn_i  (b_rstn),
    .en_i    (b_en),
    .flush_i (b_flush),
    .d_i     (b_d),
    .vld_i   (b_vld),
    .d_o     (b_d_o),
    .vld_o   (b_vld_o),
    .fill_o  (b_fill)
`ifdef DPIPE_EDGE_DET_EN
    ,
    .rise_o  (b_rise),
    .fall_o  (b_fall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so inputs/outputs are away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] d, input logic v, input logic [1:0] f);
    check({tag, ".d_o"},    32'(a_d_o),   32'(d));
    check({tag, ".vld_o"},  32'(a_vld_o), 32'(v));
    check({tag, ".fill_o"}, 32'(a_fill),  32'(f));
  endtask

  initial begin
    a_rstn = 1'b0; a_en = 1'b0; a_flush = 1'b0; a_d = 8'h00; a_vld = 1'b0;
    b_rstn = 1'b0; b_en = 1'b0; b_flush = 1'b0; b_d = 1'b0;  b_vld = 1'b0;

    // Reset held for 5 clocks
    repeat (5) step();
    check_a("reset", 8'hFF, 1'b0, 2'd0);
    check("legacy_reset.d_o", 32'(b_d_o), 32'h1);
    check("legacy_reset.vld_o", 32'(b_vld_o), 32'h0);
    check("legacy_reset.fill_o", 32'(b_fill), 32'h0);
    a_rstn = 1'b1;
    b_rstn = 1'b1;

    // Latency: three-cycle pipeline, continuous valid pushes
    a_en = 1'b1; a_vld = 1'b1;
    a_d = 8'hA5; step(); check_a("lat_e1", 8'hFF, 1'b0, 2'd1);
    a_d = 8'h3C; step(); check_a("lat_e2", 8'hFF, 1'b0, 2'd2);
    a_d = 8'h0F; step(); check_a("lat_e3", 8'hA5, 1'b1, 2'd3);
    a_d = 8'h77; step(); check_a("lat_e4", 8'h3C, 1'b1, 2'd3);
    a_d = 8'h88; step(); check_a("lat_e5", 8'h0F, 1'b1, 2'd3);

    // Flush wins over enable; 0x55 is dropped
    a_flush = 1'b1; a_d = 8'h55; a_vld = 1'b1;
    step(); check_a("flush", 8'hFF, 1'b0, 2'd0);
    a_flush = 1'b0; a_d = 8'h00; a_vld = 1'b0;
    step(); check_a("post_flush1", 8'hFF, 1'b0, 2'd0);
    step(); check_a("post_flush2", 8'hFF, 1'b0, 2'd0);
    step(); check_a("post_flush3", 8'h00, 1'b0, 2'd0);

    // Stall: two valid pushes, then en low for 4 clocks with new data on d_i
    a_vld = 1'b1;
    a_d = 8'hB1; step(); check_a("stall_push1", 8'h00, 1'b0, 2'd1);
    a_d = 8'hB2; step(); check_a("stall_push2", 8'h00, 1'b0, 2'd2);
    a_en = 1'b0; a_d = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      step();
      check_a("stall_hold", 8'h00, 1'b0, 2'd2);
    end
    a_en = 1'b1; a_d = 8'hC3;
    step(); check_a("resume1", 8'hB1, 1'b1, 2'd3);
    a_vld = 1'b0; a_d = 8'h00;
    step(); check_a("resume2", 8'hB2, 1'b1, 2'd2);
    step(); check_a("resume3", 8'hC3, 1'b1, 2'd1);
    step(); check_a("drain", 8'h00, 1'b0, 2'd0);
    a_en = 1'b0;

    // Legacy single flop: follows d_i one edge later
    b_en = 1'b1; b_vld = 1'b1;
    b_d = 1'b0; step();
    check("legacy_d0.d_o", 32'(b_d_o), 32'h0);
    check("legacy_d0.vld_o", 32'(b_vld_o), 32'h1);
    check("legacy_d0.fill_o", 32'(b_fill), 32'h1);
`ifdef DPIPE_EDGE_DET_EN
    check("edge_fall.fall_o", 32'(b_fall), 32'h1);
    check("edge_fall.rise_o", 32'(b_rise), 32'h0);
    step();
    check("edge_fall_end.fall_o", 32'(b_fall), 32'h0);
    check("edge_fall_end.rise_o", 32'(b_rise), 32'h0);
`endif
    b_d = 1'b1; step();
    check("legacy_d1.d_o", 32'(b_d_o), 32'h1);
`ifdef DPIPE_EDGE_DET_EN
    check("edge_rise.rise_o", 32'(b_rise), 32'h1);
    check("edge_rise.fall_o", 32'(b_fall), 32'h0);
    step();
    check("edge_rise_end.rise_o", 32'(b_rise), 32'h0);
`endif
    b_d = 1'b0; step();
    check("legacy_d0b.d_o", 32'(b_d_o), 32'h0);
`ifdef DPIPE_EDGE_DET_EN
    // d_o goes 0 -> 1 through flush; no edge reported
    b_flush = 1'b1; step(); b_flush = 1'b0;
    check("edge_flush.d_o", 32'(b_d_o), 32'h1);
    check("edge_flush.rise_o", 32'(b_rise), 32'h0);
    check("edge_flush.fall_o", 32'(b_fall), 32'h0);
    b_d = 1'b0; step();
`endif

    // Mid-run reset returns the line to idle-high
    b_rstn = 1'b0; step(); b_rstn = 1'b1;
    check("legacy_midreset.d_o", 32'(b_d_o), 32'h1);
    check("legacy_midreset.vld_o", 32'(b_vld_o), 32'h0);
    check("legacy_midreset.fill_o", 32'(b_fill), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
